// File: rtl/date_calendar_if.sv
// Control, load and date-output bundle for the BCD date calendar.
// The master side drives strobes and load values; the slave side returns the date.
interface date_calendar_if;
    logic        dayroll;
    logic        freeze;
    logic        inc;
    logic        dec;
    logic [1:0]  sel;
    logic        load;
    logic [7:0]  ld_dd;
    logic [7:0]  ld_mm;
    logic [15:0] ld_yyyy;
    logic [2:0]  ld_dow;
    logic [7:0]  dd;
    logic [7:0]  mm;
    logic [15:0] yyyy;
    logic [2:0]  dow;
    logic        yr_wrap;
    logic        load_err;

    modport master (
        output dayroll, freeze, inc, dec, sel, load, ld_dd, ld_mm, ld_yyyy, ld_dow,
        input  dd, mm, yyyy, dow, yr_wrap, load_err
    );

    modport slave (
        input  dayroll, freeze, inc, dec, sel, load, ld_dd, ld_mm, ld_yyyy, ld_dow,
        output dd, mm, yyyy, dow, yr_wrap, load_err
    );
endinterface

// File: rtl/date_calendar.sv
// BCD calendar with day roll, manual adjust and validated direct load.
// Day-of-week tracking is built only when DATE_CALENDAR_DOW_EN is defined.
module date_calendar #(
    parameter logic [7:0]  RESET_DD   = 8'h01,
    parameter logic [7:0]  RESET_MM   = 8'h01,
    parameter logic [15:0] RESET_YYYY = 16'h2024,
    parameter logic [15:0] YEAR_MIN   = 16'h0000,
    parameter logic [15:0] YEAR_MAX   = 16'h9999,
    parameter logic [2:0]  RESET_DOW  = 3'd0
) (
    input logic            clk,
    input logic            rst,
    date_calendar_if.slave cal
);

`ifdef DATE_CALENDAR_DOW_EN
    localparam bit DOW_EN = 1'b1;
`else
    localparam bit DOW_EN = 1'b0;
`endif

    logic [7:0]  dd_q, dd_n, mm_q, mm_n;
    logic [15:0] yyyy_q, yyyy_n;
    logic [2:0]  dow_q, dow_n;
    logic        wrap_q, wrap_n, err_q, err_n;
    logic [7:0]  md_cur;
    logic        ld_ok;

    // Leap rule works on the decimal digits, so 2100 is common and 2000 is leap.
    function automatic logic is_leap(input logic [15:0] y);
        logic [6:0] cc, yy;
        cc = 7'(y[15:12]) * 7'd10 + 7'(y[11:8]);
        yy = 7'(y[7:4]) * 7'd10 + 7'(y[3:0]);
        return (yy != 7'd0) ? (yy[1:0] == 2'b00) : (cc[1:0] == 2'b00);
    endfunction

    function automatic logic [7:0] max_day(input logic [7:0] m, input logic [15:0] y);
        case (m)
            8'h04, 8'h06, 8'h09, 8'h11: max_day = 8'h30;
            8'h02:                      max_day = is_leap(y) ? 8'h29 : 8'h28;
            default:                    max_day = 8'h31;
        endcase
    endfunction

    function automatic logic all_bcd(input logic [31:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [7:0] bcd2_inc(input logic [7:0] b);
        return (b[3:0] == 4'h9) ? {b[7:4] + 4'h1, 4'h0} : {b[7:4], b[3:0] + 4'h1};
    endfunction

    function automatic logic [7:0] bcd2_dec(input logic [7:0] b);
        return (b[3:0] == 4'h0) ? {b[7:4] - 4'h1, 4'h9} : {b[7:4], b[3:0] - 4'h1};
    endfunction

    function automatic logic [15:0] bcd4_step(input logic [15:0] b, input logic up);
        logic [15:0] r;
        logic        carry;
        r = b;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (up && r[4*i +: 4] == 4'h9) r[4*i +: 4] = 4'h0;
                else if (!up && r[4*i +: 4] == 4'h0) r[4*i +: 4] = 4'h9;
                else begin
                    r[4*i +: 4] = up ? r[4*i +: 4] + 4'h1 : r[4*i +: 4] - 4'h1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] clamp(input logic [7:0] d, input logic [7:0] md);
        return (d > md) ? md : d;
    endfunction

    assign md_cur = max_day(mm_q, yyyy_q);
    assign ld_ok  = all_bcd({cal.ld_dd, cal.ld_mm, cal.ld_yyyy})
                    && cal.ld_mm >= 8'h01 && cal.ld_mm <= 8'h12
                    && cal.ld_dd >= 8'h01 && cal.ld_dd <= max_day(cal.ld_mm, cal.ld_yyyy)
                    && cal.ld_yyyy >= YEAR_MIN && cal.ld_yyyy <= YEAR_MAX
                    && (!DOW_EN || cal.ld_dow != 3'd7);

    // Load wins over manual adjust, which wins over dayroll; losers are dropped.
    always_comb begin
        dd_n   = dd_q;
        mm_n   = mm_q;
        yyyy_n = yyyy_q;
        dow_n  = dow_q;
        wrap_n = 1'b0;
        err_n  = 1'b0;
        if (cal.load) begin
            if (ld_ok) begin
                dd_n   = cal.ld_dd;
                mm_n   = cal.ld_mm;
                yyyy_n = cal.ld_yyyy;
                if (DOW_EN) dow_n = cal.ld_dow;
            end else begin
                err_n = 1'b1;
            end
        end else if (cal.freeze) begin
            if (cal.inc ^ cal.dec) begin
                case (cal.sel)
                    2'b01: begin
                        if (cal.inc) begin
                            dd_n  = (dd_q >= md_cur) ? 8'h01 : bcd2_inc(dd_q);
                            dow_n = (dow_q >= 3'd6) ? 3'd0 : dow_q + 3'd1;
                        end else begin
                            dd_n  = (dd_q <= 8'h01) ? md_cur : bcd2_dec(dd_q);
                            dow_n = (dow_q == 3'd0) ? 3'd6 : dow_q - 3'd1;
                        end
                    end
                    2'b10: begin
                        if (cal.inc) mm_n = (mm_q >= 8'h12) ? 8'h01 : bcd2_inc(mm_q);
                        else         mm_n = (mm_q <= 8'h01) ? 8'h12 : bcd2_dec(mm_q);
                        dd_n = clamp(dd_q, max_day(mm_n, yyyy_q));
                    end
                    2'b11: begin
                        if (cal.inc) begin
                            yyyy_n = (yyyy_q >= YEAR_MAX) ? YEAR_MIN : bcd4_step(yyyy_q, 1'b1);
                            wrap_n = (yyyy_q >= YEAR_MAX);
                        end else begin
                            yyyy_n = (yyyy_q <= YEAR_MIN) ? YEAR_MAX : bcd4_step(yyyy_q, 1'b0);
                        end
                        dd_n = clamp(dd_q, max_day(mm_q, yyyy_n));
                    end
                    default: ;
                endcase
            end
        end else if (cal.dayroll) begin
            dow_n = (dow_q >= 3'd6) ? 3'd0 : dow_q + 3'd1;
            if (dd_q < md_cur) begin
                dd_n = bcd2_inc(dd_q);
            end else begin
                dd_n = 8'h01;
                if (mm_q < 8'h12) begin
                    mm_n = bcd2_inc(mm_q);
                end else begin
                    mm_n   = 8'h01;
                    yyyy_n = (yyyy_q >= YEAR_MAX) ? YEAR_MIN : bcd4_step(yyyy_q, 1'b1);
                    wrap_n = (yyyy_q >= YEAR_MAX);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dd_q   <= RESET_DD;
            mm_q   <= RESET_MM;
            yyyy_q <= RESET_YYYY;
            dow_q  <= RESET_DOW;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            dd_q   <= dd_n;
            mm_q   <= mm_n;
            yyyy_q <= yyyy_n;
            dow_q  <= DOW_EN ? dow_n : RESET_DOW;
            wrap_q <= wrap_n;
            err_q  <= err_n;
        end
    end

    assign cal.dd       = dd_q;
    assign cal.mm       = mm_q;
    assign cal.yyyy     = yyyy_q;
    assign cal.dow      = DOW_EN ? dow_q : 3'd0;
    assign cal.yr_wrap  = wrap_q;
    assign cal.load_err = err_q;

endmodule

// File: tb/tb_date_calendar.sv
// Bench for date_calendar: two instances (full year range, and 2000..2099) driven
// in lockstep and compared against a decimal-arithmetic calendar model.
module tb_date_calendar;

`ifdef DATE_CALENDAR_DOW_EN
    localparam bit DOW_EN = 1'b1;
`else
    localparam bit DOW_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dayroll = 1'b0, freeze = 1'b0, inc = 1'b0, dec = 1'b0, load = 1'b0;
    logic [1:0]  sel = 2'b00;
    logic [7:0]  ld_dd = 8'h00, ld_mm = 8'h00;
    logic [15:0] ld_yyyy = 16'h0000;
    logic [2:0]  ld_dow = 3'd0;
    int          n_checks = 0;
    int          n_fail = 0;

    int ymin[2] = '{0, 2000};
    int ymax[2] = '{9999, 2099};
    int r_d[2]  = '{28, 1};
    int r_m[2]  = '{2, 1};
    int r_y[2]  = '{2100, 2024};
    int r_w[2]  = '{0, 2};
    int m_d[2], m_m[2], m_y[2], m_w[2], m_wrap[2], m_err[2];

    date_calendar_if cal0();
    date_calendar_if cal1();

    assign cal0.dayroll = dayroll;  assign cal1.dayroll = dayroll;
    assign cal0.freeze  = freeze;   assign cal1.freeze  = freeze;
    assign cal0.inc     = inc;      assign cal1.inc     = inc;
    assign cal0.dec     = dec;      assign cal1.dec     = dec;
    assign cal0.sel     = sel;      assign cal1.sel     = sel;
    assign cal0.load    = load;     assign cal1.load    = load;
    assign cal0.ld_dd   = ld_dd;    assign cal1.ld_dd   = ld_dd;
    assign cal0.ld_mm   = ld_mm;    assign cal1.ld_mm   = ld_mm;
    assign cal0.ld_yyyy = ld_yyyy;  assign cal1.ld_yyyy = ld_yyyy;
    assign cal0.ld_dow  = ld_dow;   assign cal1.ld_dow  = ld_dow;

    date_calendar #(.RESET_DD(8'h28), .RESET_MM(8'h02), .RESET_YYYY(16'h2100)) dut0 (
        .clk(clk), .rst(rst), .cal(cal0));
    date_calendar #(.YEAR_MIN(16'h2000), .YEAR_MAX(16'h2099), .RESET_DOW(3'd2)) dut1 (
        .clk(clk), .rst(rst), .cal(cal1));

    always #5 clk = ~clk;

    function automatic bit leap(input int y);
        return (y % 4 == 0 && y % 100 != 0) || (y % 400 == 0);
    endfunction

    function automatic int mdays(input int m, input int y);
        case (m)
            2:            return leap(y) ? 29 : 28;
            4, 6, 9, 11:  return 30;
            default:      return 31;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int from_bcd(input logic [15:0] b, input int nd, inout bit ok);
        int v = 0;
        for (int i = nd - 1; i >= 0; i--) begin
            int dg;
            dg = int'(b[4*i +: 4]);
            if (dg > 9) ok = 1'b0;
            v = v * 10 + dg;
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_d[k] = r_d[k]; m_m[k] = r_m[k]; m_y[k] = r_y[k]; m_w[k] = r_w[k];
            m_wrap[k] = 0; m_err[k] = 0;
        end
    endtask

    // One calendar day/adjust/load step in plain decimal terms.
    task automatic model_step(input int k);
        bit ok;
        int d, m, y, dir, md;
        m_wrap[k] = 0;
        m_err[k]  = 0;
        if (load) begin
            ok = 1'b1;
            d  = from_bcd({8'h00, ld_dd}, 2, ok);
            m  = from_bcd({8'h00, ld_mm}, 2, ok);
            y  = from_bcd(ld_yyyy, 4, ok);
            ok = ok && m >= 1 && m <= 12 && d >= 1 && d <= mdays(m, y)
                 && y >= ymin[k] && y <= ymax[k] && (!DOW_EN || ld_dow <= 3'd6);
            if (ok) begin
                m_d[k] = d; m_m[k] = m; m_y[k] = y;
                if (DOW_EN) m_w[k] = int'(ld_dow);
            end else begin
                m_err[k] = 1;
            end
        end else if (freeze) begin
            if (inc != dec) begin
                dir = inc ? 1 : -1;
                if (sel == 2'b01) begin
                    md     = mdays(m_m[k], m_y[k]);
                    m_d[k] = (m_d[k] - 1 + dir + md) % md + 1;
                    m_w[k] = (m_w[k] + dir + 7) % 7;
                end else if (sel == 2'b10) begin
                    m_m[k] = (m_m[k] - 1 + dir + 12) % 12 + 1;
                    if (m_d[k] > mdays(m_m[k], m_y[k])) m_d[k] = mdays(m_m[k], m_y[k]);
                end else if (sel == 2'b11) begin
                    if (dir > 0 && m_y[k] >= ymax[k]) begin
                        m_y[k] = ymin[k]; m_wrap[k] = 1;
                    end else if (dir < 0 && m_y[k] <= ymin[k]) begin
                        m_y[k] = ymax[k];
                    end else begin
                        m_y[k] += dir;
                    end
                    if (m_d[k] > mdays(m_m[k], m_y[k])) m_d[k] = mdays(m_m[k], m_y[k]);
                end
            end
        end else if (dayroll) begin
            m_w[k] = (m_w[k] + 1) % 7;
            if (m_d[k] < mdays(m_m[k], m_y[k])) begin
                m_d[k]++;
            end else begin
                m_d[k] = 1;
                if (m_m[k] < 12) m_m[k]++;
                else begin
                    m_m[k] = 1;
                    if (m_y[k] >= ymax[k]) begin m_y[k] = ymin[k]; m_wrap[k] = 1; end
                    else m_y[k]++;
                end
            end
        end
    endtask

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_inst(input int k, input logic [7:0] dd, input logic [7:0] mm,
                              input logic [15:0] yy, input logic [2:0] dw,
                              input logic wr, input logic er);
        check_val($sformatf("dut%0d.dd", k), {8'h00, dd}, to_bcd(m_d[k]));
        check_val($sformatf("dut%0d.mm", k), {8'h00, mm}, to_bcd(m_m[k]));
        check_val($sformatf("dut%0d.yyyy", k), yy, to_bcd(m_y[k]));
        check_val($sformatf("dut%0d.dow", k), {13'h0, dw}, DOW_EN ? 16'(m_w[k]) : 16'h0);
        check_val($sformatf("dut%0d.yr_wrap", k), {15'h0, wr}, 16'(m_wrap[k]));
        check_val($sformatf("dut%0d.load_err", k), {15'h0, er}, 16'(m_err[k]));
    endtask

    task automatic check_output();
        check_inst(0, cal0.dd, cal0.mm, cal0.yyyy, cal0.dow, cal0.yr_wrap, cal0.load_err);
        check_inst(1, cal1.dd, cal1.mm, cal1.yyyy, cal1.dow, cal1.yr_wrap, cal1.load_err);
    endtask

    // Drive one cycle of inputs, advance the model on the edge, check on the falling edge.
    task automatic apply_stimulus(input logic dr, input logic fz, input logic i, input logic d,
                                  input logic [1:0] s, input logic ld, input logic [7:0] ldd,
                                  input logic [7:0] lmm, input logic [15:0] lyy, input logic [2:0] ldw);
        dayroll = dr; freeze = fz; inc = i; dec = d; sel = s;
        load = ld; ld_dd = ldd; ld_mm = lmm; ld_yyyy = lyy; ld_dow = ldw;
        @(posedge clk);
        if (!rst) begin model_step(0); model_step(1); end
        @(negedge clk);
        check_output();
    endtask

    task automatic idle();
        apply_stimulus(0, 0, 0, 0, 2'b00, 0, 8'h00, 8'h00, 16'h0000, 3'd0);
    endtask
    task automatic roll();
        apply_stimulus(1, 0, 0, 0, 2'b00, 0, 8'h00, 8'h00, 16'h0000, 3'd0);
    endtask
    task automatic do_load(input logic [7:0] d, input logic [7:0] m, input logic [15:0] y, input logic [2:0] w);
        apply_stimulus(0, 0, 0, 0, 2'b00, 1, d, m, y, w);
    endtask
    task automatic adjust(input logic [1:0] s, input logic i, input logic d);
        apply_stimulus(0, 1, i, d, s, 0, 8'h00, 8'h00, 16'h0000, 3'd0);
    endtask

    initial begin
        int yr, dy, mo;
        logic [15:0] lyy;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_output();
        rst = 1'b0;

        $display("[TB] leap: 28/02/2100 rolls to 01/03, 28/02/2000 rolls to 29/02");
        roll();
        check_val("leap2100_dd", {8'h00, cal0.dd}, 16'h0001);
        check_val("leap2100_mm", {8'h00, cal0.mm}, 16'h0003);
        do_load(8'h28, 8'h02, 16'h2000, 3'd1);
        roll();
        check_val("leap2000_dd", {8'h00, cal0.dd}, 16'h0029);

        $display("[TB] range wrap at 31/12/2099");
        do_load(8'h31, 8'h12, 16'h2099, 3'd4);
        roll();
        check_val("wrap_yyyy", cal1.yyyy, 16'h2000);
        check_val("wrap_pulse", {15'h0, cal1.yr_wrap}, 16'h0001);
        idle();
        check_val("wrap_pulse_end", {15'h0, cal1.yr_wrap}, 16'h0000);

        $display("[TB] invalid and valid load");
        do_load(8'h30, 8'h02, 16'h2024, 3'd2);
        check_val("bad_load_err", {15'h0, cal0.load_err}, 16'h0001);
        idle();
        check_val("bad_load_err_end", {15'h0, cal0.load_err}, 16'h0000);
        do_load(8'h29, 8'h02, 16'h2024, 3'd3);
        check_val("good_load_dd", {8'h00, cal1.dd}, 16'h0029);
        check_val("good_load_dow", {13'h0, cal1.dow}, DOW_EN ? 16'h0003 : 16'h0000);
        do_load(8'h01, 8'h01, 16'h2024, 3'd7);
        do_load(8'h01, 8'h1A, 16'h2024, 3'd0);
        do_load(8'h15, 8'h06, 16'h1999, 3'd0);

        $display("[TB] clamp on month and year adjust");
        do_load(8'h31, 8'h01, 16'h2023, 3'd0);
        adjust(2'b10, 1, 0);
        check_val("clamp_mm_dd", {8'h00, cal0.dd}, 16'h0028);
        do_load(8'h29, 8'h02, 16'h2024, 3'd0);
        adjust(2'b11, 0, 1);
        check_val("clamp_yr_dd", {8'h00, cal1.dd}, 16'h0028);
        check_val("clamp_yr_yyyy", cal1.yyyy, 16'h2023);
        adjust(2'b01, 0, 1);
        adjust(2'b01, 1, 0);
        adjust(2'b01, 1, 0);
        adjust(2'b10, 0, 1);
        adjust(2'b00, 1, 0);

        $display("[TB] priority: load over freeze over dayroll");
        apply_stimulus(1, 1, 1, 0, 2'b01, 1, 8'h10, 8'h05, 16'h2024, 3'd5);
        check_val("prio_dd", {8'h00, cal0.dd}, 16'h0010);
        adjust(2'b01, 1, 1);
        check_val("incdec_dd", {8'h00, cal0.dd}, 16'h0010);
        apply_stimulus(1, 1, 0, 0, 2'b00, 0, 8'h00, 8'h00, 16'h0000, 3'd0);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 5))
                0: yr = 2099;
                1: yr = 9999;
                2: yr = 2000;
                3: yr = 0;
                default: yr = $urandom_range(1995, 2105);
            endcase
            dy = $urandom_range(0, 32);
            mo = $urandom_range(0, 13);
            if ($urandom_range(0, 3) == 0) begin dy = 31; mo = 12; end
            lyy = ($urandom_range(0, 9) == 0) ? 16'($urandom) : to_bcd(yr);
            apply_stimulus($urandom_range(0, 1) != 0, $urandom_range(0, 9) < 3,
                           $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                           2'($urandom_range(0, 3)), $urandom_range(0, 9) == 0,
                           8'(to_bcd(dy)), 8'(to_bcd(mo)), lyy, 3'($urandom_range(0, 7)));
        end

        $display("[TB] asynchronous reset mid-count");
        roll();
        roll();
        dayroll = 1'b1;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_output();
        @(negedge clk);
        roll();
        rst = 1'b0;
        roll();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/date_calendar.md
DATE_CALENDAR -- requirements
Module: date_calendar

Interface
REQ-001 SHALL have parameter RESET_DD, 8'h01: BCD day loaded at reset.
REQ-002 SHALL have parameter RESET_MM, 8'h01: BCD month loaded at reset.
REQ-003 SHALL have parameter RESET_YYYY, 16'h2024: BCD year loaded at reset.
REQ-004 SHALL have parameter YEAR_MIN, 16'h0000, and parameter YEAR_MAX, 16'h9999: inclusive BCD year range, with YEAR_MIN <= YEAR_MAX.
REQ-005 SHALL have parameter RESET_DOW, 3'd0: day of week at reset, 0 = Monday … 6 = Sunday.
REQ-006 SHALL have ports clk (in, 1, clock) and rst (in, 1, reset). The design uses one clock; rst is asynchronous and active-high.
REQ-007 SHALL have ports dayroll (in, 1, one-cycle advance-day strobe) and freeze (in, 1, manual-adjust mode).
REQ-008 SHALL have ports inc, dec (in, 1 each, adjust strobes) and sel (in, 2; 01 = day, 10 = month, 11 = year, 00 = none).
REQ-009 SHALL have ports load (in, 1, direct-set strobe), ld_dd (in, 8), ld_mm (in, 8), ld_yyyy (in, 16) and ld_dow (in, 3): BCD/DOW load values.
REQ-010 SHALL have ports dd (out, 8), mm (out, 8) and yyyy (out, 16): BCD date, registered.
REQ-011 SHALL have ports dow (out, 3, day of week), yr_wrap (out, 1, range-wrap pulse) and load_err (out, 1, rejected-load pulse).

Function
REQ-012 SHALL evaluate the leap rule on decimal digits, never on the binary value of the BCD word. With CC = yyyy[15:8] and YY = yyyy[7:0]: leap = (YY%4 == 0 and YY != 00) or (YY == 00 and CC%4 == 0).
REQ-013 SHALL set maxd = 31 for months 01/03/05/07/08/10/12, 30 for 04/06/09/11, and 29 or 28 for 02 depending on leap.
REQ-014 SHALL apply events in this priority each cycle: load, then freeze-adjust, then dayroll. Lower-priority events in the same cycle are discarded.
REQ-015 SHALL, on load, accept the ld_* values only if every nibble is <= 9, 01 <= ld_mm <= 12, 01 <= ld_dd <= maxd(ld_mm, ld_yyyy), YEAR_MIN <= ld_yyyy <= YEAR_MAX, and ld_dow <= 6.
REQ-016 SHALL, when a load fails validation, leave all state unchanged and drive load_err = 1 for exactly the following cycle.
REQ-017 SHALL, on dayroll with freeze = 0, increment dd in BCD (09 -> 10). When dd == maxd, dd becomes 01 and mm increments; 12 -> 01 increments yyyy in BCD.
REQ-018 SHALL, when the year reaches YEAR_MAX and a further increment occurs, wrap yyyy to YEAR_MIN and pulse yr_wrap for one cycle. This applies both to dayroll and to a manual year inc.
REQ-019 SHALL, with freeze = 1 and inc and dec both high, make no change to state.
REQ-020 SHALL, with freeze = 1 and sel = 01, move dd by ±1 with wrap maxd <-> 01, and move dow by ±1 modulo 7.
REQ-021 SHALL, with freeze = 1 and sel = 10, move mm by ±1 with wrap 12 <-> 01. With sel = 11, move yyyy by ±1 with wrap YEAR_MAX <-> YEAR_MIN; the decrement wrap does not pulse yr_wrap.
REQ-022 SHALL, on a month or year adjust, clamp dd in the same cycle to maxd computed from the new mm/yyyy values. dow is unchanged by month/year adjust.
REQ-023 SHALL ignore dayroll while freeze = 1, without queuing it.
REQ-024 SHALL ignore inc/dec while freeze = 0 or sel = 00.
REQ-025 SHALL have a latency of one clock from any strobe to the updated outputs.

Reset
REQ-026 SHALL, on rst assertion, immediately force dd = RESET_DD, mm = RESET_MM, yyyy = RESET_YYYY, dow = RESET_DOW, yr_wrap = 0 and load_err = 0, including mid-operation.
REQ-027 SHALL ignore all strobes while rst is high and resume on the first clock edge after deassertion.

Configuration
REQ-028 SHALL, with DATE_CALENDAR_DOW_EN defined, track dow as specified.
REQ-029 SHALL, without DATE_CALENDAR_DOW_EN, tie dow to 3'd0, ignore ld_dow, and drop the ld_dow <= 6 check from load validation.

Verification
REQ-030 SHALL cover this leap scenario: reset with RESET_YYYY = 16'h2100, mm = 02, dd = 28, then dayroll -> dd = 01, mm = 03 (2100 is not a leap year). Repeat with 2000 -> dd = 29.
REQ-031 SHALL cover this range-wrap scenario: YEAR_MIN = 16'h2000, YEAR_MAX = 16'h2099, load 31/12/2099, then dayroll -> 01/01/2000 with yr_wrap high for one cycle.
REQ-032 SHALL cover this invalid-load scenario: load 30/02/2024 -> state unchanged and load_err pulses for one cycle. Then load 29/02/2024 with ld_dow = 3 -> accepted, dow = 3.
REQ-033 SHALL cover this clamp scenario: freeze = 1, sel = 10, starting from 31/01/2023, inc -> 28/02/2023. Then sel = 11, starting from 29/02/2024, dec -> 28/02/2023.
REQ-034 SHALL cover this priority scenario: load (valid), freeze = 1 and dayroll asserted in one cycle -> only the load takes effect. inc and dec together -> no change.
REQ-035 SHALL cover this reset scenario: assert rst asynchronously between clock edges mid-count -> outputs equal the reset parameters before the next edge.
